// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the program-counter unit
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int          DEFAULT_STEP         = 4;

    // Clears the byte-offset bits below one instruction step.
    function automatic logic [63:0] align_mask(input int step);
        return ~(64'(step) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack, oldest entry overwritten when full
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      count;
    logic [PW-1:0]    top_idx;
    logic             pop_ok;

    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;

    // Simultaneous pop and push replaces the top entry in place.
    always_ff @(posedge clock) begin
        if (push && pop_ok) begin
            mem[top_idx] <= push_data;
        end else if (push) begin
            mem[ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !pop_ok) begin
            ptr <= ptr + PW'(1);
            if (!full) begin
                count <= count + (PW+1)'(1);
            end
        end else if (pop_ok && !push) begin
            ptr   <= ptr - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch-stage PC with handshake, redirect, trap, halt and RAS
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = DEFAULT_STEP,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc_out,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic             trap_en,
    input  logic             halt_req,
    input  logic             resume,
    output logic             halted,
    output logic             ras_underflow
);

    localparam logic [WIDTH-1:0] ALIGN  = WIDTH'(align_mask(STEP));
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    pc_state_t        state, state_next;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] seq_pc;
    logic             underflow_next;
    logic             ras_push, ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;

    assign seq_pc      = pc_out + STEP_W;
    assign fetch_valid = (state == RUN);

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      ()
    );

    always_comb begin
        state_next     = state;
        pc_next        = pc_out;
        underflow_next = 1'b0;
        ras_push       = 1'b0;
        ras_pop        = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (trap_en) begin
                    pc_next = TRAP_VECTOR;
                end else if (ret_en) begin
                    if (!ras_empty) begin
                        pc_next  = ras_top;
                        ras_pop  = 1'b1;
                        ras_push = redirect_en && call_en;
                    end else begin
                        pc_next        = TRAP_VECTOR;
                        underflow_next = 1'b1;
                    end
                end else if (redirect_en) begin
                    pc_next  = redirect_target & ALIGN;
                    ras_push = call_en;
                end else if (fetch_ready) begin
                    pc_next = seq_pc;
                end
                // The PC move of the halting cycle still lands before HALT.
                if (halt_req && !trap_en) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (trap_en) begin
                    pc_next    = TRAP_VECTOR;
                    state_next = RUN;
                end else if (resume) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= BOOT;
            pc_out        <= RESET_VECTOR;
            halted        <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            state         <= state_next;
            pc_out        <= pc_next;
            halted        <= (state_next == HALT);
            ras_underflow <= underflow_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clock;
    logic        reset;
    logic        fetch_ready;
    logic        redirect_en;
    logic [31:0] redirect_target;
    logic        call_en;
    logic        ret_en;
    logic        trap_en;
    logic        halt_req;
    logic        resume;

    logic        fetch_valid;
    logic [31:0] pc_out;
    logic        halted;
    logic        ras_underflow;

    logic        fetch_valid8;
    logic [7:0]  pc_out8;
    logic        halted8;
    logic        ras_underflow8;

    int vectors;
    int miscompares;

    // Reference model: 0 = boot, 1 = run, 2 = halt; RAS is a bounded queue
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_uf;
    logic        m_halted;

    pc_fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .fetch_ready     (fetch_ready),
        .fetch_valid     (fetch_valid),
        .pc_out          (pc_out),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .call_en         (call_en),
        .ret_en          (ret_en),
        .trap_en         (trap_en),
        .halt_req        (halt_req),
        .resume          (resume),
        .halted          (halted),
        .ras_underflow   (ras_underflow)
    );

    pc_fetch_unit #(
        .WIDTH        (8),
        .RESET_VECTOR (8'h00),
        .TRAP_VECTOR  (8'h80)
    ) dut8 (
        .clock           (clock),
        .reset           (reset),
        .fetch_ready     (fetch_ready),
        .fetch_valid     (fetch_valid8),
        .pc_out          (pc_out8),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target[7:0]),
        .call_en         (call_en),
        .ret_en          (ret_en),
        .trap_en         (trap_en),
        .halt_req        (halt_req),
        .resume          (resume),
        .halted          (halted8),
        .ras_underflow   (ras_underflow8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_step();
        logic [31:0] old_pc;
        old_pc = m_pc;
        m_uf   = 1'b0;
        if (!reset) begin
            m_state = 0;
            m_pc    = 32'h0;
            m_ras.delete();
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (trap_en) begin
                m_pc = 32'h100;
            end else if (ret_en) begin
                if (m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                    if (redirect_en && call_en) m_ras.push_back(old_pc + 32'd4);
                end else begin
                    m_pc = 32'h100;
                    m_uf = 1'b1;
                end
            end else if (redirect_en) begin
                if (call_en) begin
                    m_ras.push_back(old_pc + 32'd4);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                end
                m_pc = {redirect_target[31:2], 2'b00};
            end else if (fetch_ready) begin
                m_pc = old_pc + 32'd4;
            end
            if (halt_req && !trap_en) m_state = 2;
        end else begin
            if (trap_en) begin
                m_pc    = 32'h100;
                m_state = 1;
            end else if (resume) begin
                m_state = 1;
            end
        end
        m_halted = (m_state == 2);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        reset           = 1'b1;
        fetch_ready     = 1'b0;
        redirect_en     = 1'b0;
        redirect_target = 32'h0;
        call_en         = 1'b0;
        ret_en          = 1'b0;
        trap_en         = 1'b0;
        halt_req        = 1'b0;
        resume          = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (pc_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0);
        end
        vectors++;
        if ({fetch_valid, halted, ras_underflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000", {fetch_valid, halted, ras_underflow});
        end
    endtask

    task automatic test_boot_seq();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0;
        exp_pc[1] = 32'h4;
        exp_pc[2] = 32'h8;
        reset       = 1'b1;
        fetch_ready = 1'b1;
        vectors++;
        if (fetch_valid !== 1'b0 || pc_out !== 32'h0) begin
            miscompares++;
            $display("FAIL boot_cycle: got fv=%b pc=%h expected fv=0 pc=0", fetch_valid, pc_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (fetch_valid !== 1'b1 || pc_out !== exp_pc[i]) begin
                miscompares++;
                $display("FAIL boot_seq[%0d]: got fv=%b pc=%h expected fv=1 pc=%h",
                         i, fetch_valid, pc_out, exp_pc[i]);
            end
        end
    endtask

    task automatic test_stall();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (pc_out !== 32'h8) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %h expected %h", i, pc_out, 32'h8);
            end
        end
        fetch_ready = 1'b1;
        tick();
        vectors++;
        if (pc_out !== 32'hC) begin
            miscompares++;
            $display("FAIL stall_release: got %h expected %h", pc_out, 32'hC);
        end
    endtask

    task automatic test_call_ret();
        tick();
        vectors++;
        if (pc_out !== 32'h10) begin
            miscompares++;
            $display("FAIL call_start: got %h expected %h", pc_out, 32'h10);
        end
        redirect_en     = 1'b1;
        call_en         = 1'b1;
        redirect_target = 32'h203;
        tick();
        vectors++;
        if (pc_out !== 32'h200) begin
            miscompares++;
            $display("FAIL call_target: got %h expected %h", pc_out, 32'h200);
        end
        redirect_en = 1'b0;
        call_en     = 1'b0;
        tick();
        fetch_ready = 1'b0;
        ret_en      = 1'b1;
        tick();
        vectors++;
        if (pc_out !== 32'h14) begin
            miscompares++;
            $display("FAIL ret_target: got %h expected %h", pc_out, 32'h14);
        end
        tick();
        vectors++;
        if (pc_out !== 32'h100 || ras_underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow: got pc=%h uf=%b expected pc=100 uf=1", pc_out, ras_underflow);
        end
        ret_en = 1'b0;
        tick();
        vectors++;
        if (ras_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_pulse: got %b expected 0", ras_underflow);
        end
        fetch_ready = 1'b1;
        tick();
        trap_en         = 1'b1;
        redirect_en     = 1'b1;
        redirect_target = 32'h40;
        tick();
        vectors++;
        if (pc_out !== 32'h100) begin
            miscompares++;
            $display("FAIL trap_priority: got %h expected %h", pc_out, 32'h100);
        end
        trap_en = 1'b0;
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [5];
        exp_ret[0] = 32'h44;
        exp_ret[1] = 32'h34;
        exp_ret[2] = 32'h24;
        exp_ret[3] = 32'h14;
        exp_ret[4] = 32'h100;
        redirect_en     = 1'b1;
        call_en         = 1'b0;
        redirect_target = 32'h0;
        tick();
        call_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            redirect_target = 32'(i + 1) * 32'h10;
            tick();
            vectors++;
            if (pc_out !== redirect_target) begin
                miscompares++;
                $display("FAIL ovf_call[%0d]: got %h expected %h", i, pc_out, redirect_target);
            end
        end
        redirect_en = 1'b0;
        call_en     = 1'b0;
        ret_en      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (pc_out !== exp_ret[i] || ras_underflow !== (i == 4)) begin
                miscompares++;
                $display("FAIL ovf_ret[%0d]: got pc=%h uf=%b expected pc=%h uf=%b",
                         i, pc_out, ras_underflow, exp_ret[i], (i == 4));
            end
        end
        ret_en = 1'b0;
    endtask

    task automatic test_halt();
        set_idle();
        reset = 1'b0;
        tick();
        reset       = 1'b1;
        fetch_ready = 1'b1;
        repeat (3) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        vectors++;
        if (pc_out !== 32'hC || halted !== 1'b1 || fetch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_entry: got pc=%h h=%b fv=%b expected pc=c h=1 fv=0", pc_out, halted, fetch_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (pc_out !== 32'hC || halted !== 1'b1) begin
                miscompares++;
                $display("FAIL halt_hold[%0d]: got pc=%h h=%b expected pc=c h=1", i, pc_out, halted);
            end
        end
        halt_req = 1'b1;
        resume   = 1'b1;
        tick();
        halt_req = 1'b0;
        resume   = 1'b0;
        vectors++;
        if (halted !== 1'b0 || fetch_valid !== 1'b1 || pc_out !== 32'hC) begin
            miscompares++;
            $display("FAIL resume_wins: got pc=%h h=%b fv=%b expected pc=c h=0 fv=1", pc_out, halted, fetch_valid);
        end
        tick();
        vectors++;
        if (pc_out !== 32'h10) begin
            miscompares++;
            $display("FAIL resume_fetch: got %h expected %h", pc_out, 32'h10);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        reset    = 1'b0;
        tick();
        vectors++;
        if (pc_out !== 32'h0 || halted !== 1'b0 || fetch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_halt: got pc=%h h=%b fv=%b expected pc=0 h=0 fv=0", pc_out, halted, fetch_valid);
        end
        reset = 1'b1;
    endtask

    task automatic test_wrap8();
        set_idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        redirect_en     = 1'b1;
        redirect_target = 32'hFC;
        tick();
        vectors++;
        if (pc_out8 !== 8'hFC) begin
            miscompares++;
            $display("FAIL wrap8_setup: got %h expected %h", pc_out8, 8'hFC);
        end
        redirect_en = 1'b0;
        fetch_ready = 1'b1;
        tick();
        vectors++;
        if (pc_out8 !== 8'h00) begin
            miscompares++;
            $display("FAIL wrap8: got %h expected %h", pc_out8, 8'h00);
        end
    endtask

    task automatic test_random();
        set_idle();
        for (int n = 0; n < 1500; n++) begin
            reset           = ($urandom_range(0, 99) != 0);
            fetch_ready     = ($urandom_range(0, 3) != 0);
            redirect_en     = ($urandom_range(0, 7) == 0);
            redirect_target = $urandom;
            call_en         = ($urandom_range(0, 1) == 0);
            ret_en          = ($urandom_range(0, 9) == 0);
            trap_en         = ($urandom_range(0, 19) == 0);
            halt_req        = ($urandom_range(0, 14) == 0);
            resume          = ($urandom_range(0, 3) == 0);
            tick();
            vectors++;
            if (pc_out !== m_pc) begin
                miscompares++;
                $display("FAIL rand_pc[%0d]: got %h expected %h", n, pc_out, m_pc);
            end
            vectors++;
            if (fetch_valid !== (m_state == 1)) begin
                miscompares++;
                $display("FAIL rand_fv[%0d]: got %b expected %b", n, fetch_valid, (m_state == 1));
            end
            vectors++;
            if (halted !== m_halted || ras_underflow !== m_uf) begin
                miscompares++;
                $display("FAIL rand_flags[%0d]: got h=%b uf=%b expected h=%b uf=%b",
                         n, halted, ras_underflow, m_halted, m_uf);
            end
        end
        set_idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_state     = 0;
        m_pc        = 32'h0;
        m_uf        = 1'b0;
        m_halted    = 1'b0;
        set_idle();
        test_reset();
        test_boot_seq();
        test_stall();
        test_call_ret();
        test_ras_overflow();
        test_halt();
        test_wrap8();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
